// File: rtl/fpu_mul_result_buffer_if.sv
// Handshake bundle between the FP multiplier, its result buffer and the consumer.
// master = environment side (multiplier + consumer), slave = the buffer itself.
interface fpu_mul_result_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_exception;
  logic        in_overflow;
  logic        in_underflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_result, in_exception, in_overflow, in_underflow, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_result, in_exception, in_overflow, in_underflow, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fpu_mul_result_buffer.sv
// Result FIFO behind the single-precision multiplier, with sticky exception status.
// Build option FPU_MUL_BUF_CANON_NAN_EN: exception results are stored as quiet NaN 32'h7FC00000.
module fpu_mul_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  fpu_mul_result_buffer_if.slave bus,
  input  logic                sticky_clr,
  output logic [2:0]          sticky_flags,
  output logic [PTR_W:0]      count
);

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [31:0]      mem_result [DEPTH];
  logic [2:0]       mem_flags  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [2:0]       in_flags;
  logic [31:0]      wr_result;

  always_comb begin
    in_flags      = {bus.in_exception, bus.in_overflow, bus.in_underflow};
    bus.in_ready  = (count != FULL);
    bus.out_valid = (count != '0);
    push          = bus.in_valid & bus.in_ready;
    pop           = bus.out_valid & bus.out_ready;
    bus.out_result = mem_result[rd_ptr];
    bus.out_flags  = mem_flags[rd_ptr];
  end

  always_comb begin
`ifdef FPU_MUL_BUF_CANON_NAN_EN
    wr_result = bus.in_exception ? 32'h7FC0_0000 : bus.in_result;
`else
    wr_result = bus.in_result;
`endif
  end

  // Storage is not reset; rst_n only gates the write so a reset cycle never completes a push.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_result[wr_ptr] <= wr_result;
      mem_flags[wr_ptr]  <= in_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A clear keeps only the flags of a push landing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else if (sticky_clr) begin
      sticky_flags <= push ? in_flags : '0;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
    end
  end

endmodule

// File: doc/fpu_mul_result_buffer.md
Name: fpu_mul_result_buffer

Overview:
- Downstream stage of the combinational single-precision multiplier.
- Captures each multiplier result word plus its exception/overflow/underflow flags into a small FIFO.
- Presents entries to the consumer (register file writeback / bus) with a valid/ready handshake.
- Keeps sticky, software-clearable status flags, accumulated as results are accepted.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, >= 2
PTR_W, 2, pointer width; must equal log2(DEPTH)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  multiplier result present this cycle
in_ready  output  1  buffer can accept an entry this cycle
in_result  input  32  IEEE-754 single result from multiplier
in_exception  input  1  multiplier exception flag (operand exponent 255)
in_overflow  input  1  multiplier overflow flag
in_underflow  input  1  multiplier underflow flag
out_valid  output  1  head entry available
out_ready  input  1  consumer takes head entry this cycle
out_result  output  32  head entry result word
out_flags  output  3  head entry flags {exception, overflow, underflow}
sticky_flags  output  3  accumulated {exception, overflow, underflow}
sticky_clr  input  1  clear sticky flags
count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values (rst_n low at a rising edge):
  - count=0, read/write pointers=0, sticky_flags=0.
  - out_valid=0, in_ready=1.
  - out_result and out_flags read storage at the head pointer; storage is not cleared, so their value is don't-care while out_valid=0.
  - Reset mid-operation discards all stored entries; no handshake completes on a reset cycle.
- Push: occurs when in_valid & in_ready at a rising edge.
  - Writes {result, flags} at wr_ptr.
  - wr_ptr increments modulo DEPTH (natural wrap of the PTR_W-bit pointer).
- Pop: occurs when out_valid & out_ready at a rising edge; rd_ptr increments modulo DEPTH.
- Handshake outputs:
  - in_ready = (count != DEPTH). No pass-through when full: a push is refused when full even if a pop occurs in the same cycle.
  - out_valid = (count != 0).
  - out_result/out_flags are driven directly from the head storage entry (registered storage, no combinational path from in_* to out_*).
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N (first pop possible at edge N+1). No bypass when empty.
- Occupancy update per edge:
  - push only: count+1
  - pop only: count-1
  - both: count unchanged; both pointers advance
  - neither: unchanged
- Boundary conditions:
  - Full (count=DEPTH): in_ready=0; in_valid ignored; data held upstream.
  - Empty (count=0): out_valid=0; out_ready ignored; no pointer movement.
  - Simultaneous push and pop at count=1: count stays 1; out_* presents the new entry next cycle.
- Sticky flags:
  - On each push, sticky_flags |= pushed flags.
  - sticky_clr at an edge sets sticky_flags to exactly the flags of any push accepted in that same edge, 0 otherwise; a set in the same cycle as a clear wins.
  - Pops do not affect sticky_flags.
- Data integrity: stored result word is exactly the pushed word, except as modified by the optional feature below; flags are stored unmodified.

Optional Feature:
- Macro: FPU_MUL_BUF_CANON_NAN_EN.
- Defined: on push, when in_exception=1, the stored result is replaced with canonical quiet NaN 32'h7FC00000. Flags are stored unchanged.
- Not defined: in_result is stored verbatim, so exception results pass through as delivered by the multiplier (32'h00000000).
- Sticky behaviour, handshake, and timing are identical in both builds.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then push 32'h40C00000 (6.0), flags 000 -> after the edge out_valid=1, out_result=32'h40C00000, out_flags=000, count=1, sticky_flags=000.
- Push 4 entries with out_ready=0 -> count=4, in_ready=0. Fifth in_valid is not accepted. Pop all 4 with out_ready=1 -> in-order results, count=0, out_valid=0.
- Keep count=2; drive in_valid and out_ready together for 6 cycles -> count stays 2, pointers wrap past DEPTH, output order is preserved across the wrap.
- Push with flags 010 (result 32'h7F7FFFFF), then flags 001 -> sticky_flags=011. Assert sticky_clr alone -> 000. Assert sticky_clr together with a push of flags 100 -> 100.
- Push in_exception=1, in_result=32'h00000000 -> out_result=32'h7FC00000 when FPU_MUL_BUF_CANON_NAN_EN is defined, 32'h00000000 when it is not; out_flags=100 in both builds.
- Fill 3 entries, assert rst_n=0 for 1 cycle mid-stream -> count=0, out_valid=0, in_ready=1, sticky_flags=000; the next push appears as the sole entry.
